// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: control levels,
// bus widths and the fetch FSM state encoding.
package ifetch_ctrl_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic FLUSH       = 1'b1;
  localparam logic Stall       = 1'b1;
  localparam int   RegBus      = 32;
  localparam int   InstAddrBus = 32;
  localparam int   InstBus     = 32;

  typedef enum logic [1:0] {
    IfReq     = 2'b00,
    IfWait    = 2'b01,
    IfHold    = 2'b10,
    IfDiscard = 2'b11
  } if_state_e;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction memory bus: single-outstanding request/response handshake.
// The fetch controller is the master, the memory is the slave.
interface ifetch_ctrl_if
  import ifetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/ifetch_ctrl_perf.sv
// Fetch performance counters (module ifetch_perf): stall cycles (wrapping)
// and dropped responses (saturating). Only compiled when IFETCH_PERF_EN is defined.
`ifdef IFETCH_PERF_EN
module ifetch_perf
  import ifetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_evt,
  input  logic              discard_evt,
  output logic [RegBus-1:0] stall_cnt,
  output logic [15:0]       discard_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      stall_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      if (stall_evt)
        stall_cnt <= stall_cnt + RegBus'(1);
      // Discard count sticks at all-ones instead of wrapping
      if (discard_evt && (discard_cnt != 16'hFFFF))
        discard_cnt <= discard_cnt + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding memory fetch, delivery to IF/ID,
// fetch stall request and flush discard. Optional counters under IFETCH_PERF_EN.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              flush,
  ifetch_ctrl_if.master     bus,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              stallreq_if,
  output logic [RegBus-1:0] perf_stall_cnt,
  output logic [15:0]       perf_discard_cnt
);

  if_state_e         state, state_nxt;
  logic [ADDR_W-1:0] req_pc;
  logic [DATA_W-1:0] buf_inst;
  logic              is_flush, is_stall;
  logic              accept, capture;

  assign is_flush = (flush == FLUSH);
  assign is_stall = (stall == Stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable)
      state <= IfReq;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      req_pc   <= '0;
      buf_inst <= '0;
    end else begin
      if (accept)
        req_pc <= pc;
      if (capture)
        buf_inst <= bus.inst_rdata;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.inst_req  = 1'b0;
    bus.inst_addr = pc;
    inst_valid_o  = 1'b0;
    inst_o        = '0;
    accept        = 1'b0;
    capture       = 1'b0;
    case (state)
      IfReq: begin
        bus.inst_req = (rst != RstEnable);
        // A flush racing the acceptance still owes us a response, which must be eaten
        if (bus.inst_req && bus.inst_addr_ok) begin
          accept    = 1'b1;
          state_nxt = is_flush ? IfDiscard : IfWait;
        end
      end
      IfWait: begin
        if (bus.inst_data_ok) begin
          state_nxt = IfReq;
          if (!is_flush && is_stall) begin
            capture   = 1'b1;
            state_nxt = IfHold;
          end else if (!is_flush) begin
            inst_valid_o = 1'b1;
            inst_o       = bus.inst_rdata;
          end
        end else if (is_flush) begin
          state_nxt = IfDiscard;
        end
      end
      IfHold: begin
        if (is_flush) begin
          state_nxt = IfReq;
        end else if (!is_stall) begin
          inst_valid_o = 1'b1;
          inst_o       = buf_inst;
          state_nxt    = IfReq;
        end
      end
      IfDiscard: begin
        if (bus.inst_data_ok)
          state_nxt = IfReq;
      end
      default: state_nxt = IfReq;
    endcase
  end

  assign inst_pc_o   = req_pc;
  assign stallreq_if = !inst_valid_o && !is_stall;

`ifdef IFETCH_PERF_EN
  logic drop;

  assign drop = (bus.inst_data_ok && ((state == IfWait && is_flush) || state == IfDiscard))
              || (state == IfHold && is_flush);

  ifetch_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_evt   (stallreq_if),
    .discard_evt (drop),
    .stall_cnt   (perf_stall_cnt),
    .discard_cnt (perf_discard_cnt)
  );
`else
  assign perf_stall_cnt   = '0;
  assign perf_discard_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ifetch_ctrl;
  import ifetch_ctrl_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc;
  logic          stall, flush;
  logic          inst_valid_o;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          stallreq_if;
  logic [31:0]   perf_stall_cnt;
  logic [15:0]   perf_discard_cnt;

  ifetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ifetch_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .stall            (stall),
    .flush            (flush),
    .bus              (bus),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .stallreq_if      (stallreq_if),
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_discard_cnt (perf_discard_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction-level model: an accepted fetch is outstanding until its
  // response; a flush marks it dead; a stalled response is parked.
  bit          m_txn, m_dead, m_held;
  logic [31:0] m_pc, m_held_data;
  logic [31:0] m_stall_cnt;
  logic [15:0] m_disc_cnt;
  int          mem_lat;

  logic        s_req, s_valid, s_stallreq;
  logic [31:0] s_addr, s_inst, s_pc, s_pstall;
  logic [15:0] s_pdisc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h24000000;
  endfunction

  task automatic modelReset();
    m_txn = 0; m_dead = 0; m_held = 0;
    m_pc = '0; m_held_data = '0;
    m_stall_cnt = '0; m_disc_cnt = '0;
    mem_lat = 0;
  endtask

  task automatic checkOutput();
    bit          resp, e_req, e_valid, e_stallreq;
    logic [31:0] e_inst, e_pstall;
    logic [15:0] e_pdisc;
    resp       = m_txn && bus.inst_data_ok;
    e_req      = !m_txn && !m_held;
    e_valid    = (resp && !m_dead && !flush && !stall) || (m_held && !flush && !stall);
    e_inst     = !e_valid ? 32'h0 : (m_held ? m_held_data : bus.inst_rdata);
    e_stallreq = !e_valid && !stall;
`ifdef IFETCH_PERF_EN
    e_pstall = m_stall_cnt;
    e_pdisc  = m_disc_cnt;
`else
    e_pstall = 32'h0;
    e_pdisc  = 16'h0;
`endif
    s_req = bus.inst_req;       s_addr = bus.inst_addr;
    s_valid = inst_valid_o;     s_inst = inst_o;
    s_pc = inst_pc_o;           s_stallreq = stallreq_if;
    s_pstall = perf_stall_cnt;  s_pdisc = perf_discard_cnt;

    chk("inst_req", {31'b0, s_req}, {31'b0, e_req});
    if (e_req) chk("inst_addr", s_addr, pc);
    chk("inst_valid_o", {31'b0, s_valid}, {31'b0, e_valid});
    chk("inst_o", s_inst, e_inst);
    chk("inst_pc_o", s_pc, m_pc);
    chk("stallreq_if", {31'b0, s_stallreq}, {31'b0, e_stallreq});
    chk("perf_stall_cnt", s_pstall, e_pstall);
    chk("perf_discard_cnt", {16'b0, s_pdisc}, {16'b0, e_pdisc});

    // Advance the model to the state after the coming rising edge
    if (e_stallreq) m_stall_cnt = m_stall_cnt + 1;
    if ((resp && (m_dead || flush)) || (m_held && flush))
      if (m_disc_cnt != 16'hFFFF) m_disc_cnt = m_disc_cnt + 1;
    if (m_held && (flush || !stall)) m_held = 0;
    if (resp) begin
      m_txn = 0;
      if (!m_dead && !flush && stall) begin
        m_held = 1;
        m_held_data = bus.inst_rdata;
      end
      m_dead = 0;
    end else if (m_txn && flush) begin
      m_dead = 1;
    end
    if (e_req && bus.inst_addr_ok) begin
      m_txn = 1; m_dead = flush; m_pc = pc;
      mem_lat = $urandom_range(0, 2);
    end else if (m_txn && mem_lat > 0) begin
      mem_lat--;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic applyStimulus(input logic [31:0] p, input logic st, input logic fl,
                               input logic aok, input logic dok, input logic [31:0] rd);
    pc = p; stall = st; flush = fl;
    bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.inst_rdata = rd;
    #2;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic randomStep();
    logic [31:0] p, rd;
    logic        st, fl, aok, dok;
    p = pc;
    if ($urandom_range(0, 3) == 0)
      p = ($urandom_range(0, 1) == 1) ? pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
    st  = ($urandom_range(0, 3) == 0);
    fl  = ($urandom_range(0, 15) == 0);
    aok = ($urandom_range(0, 2) != 0);
    dok = m_txn ? (mem_lat == 0) : ($urandom_range(0, 7) == 0);
    rd  = m_txn ? mem_word(m_pc) : $urandom;
    applyStimulus(p, st, fl, aok, dok, rd);
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, ".inst_req"}, {31'b0, bus.inst_req}, 32'h0);
    chk({tag, ".inst_valid_o"}, {31'b0, inst_valid_o}, 32'h0);
    chk({tag, ".inst_o"}, inst_o, 32'h0);
    chk({tag, ".inst_pc_o"}, inst_pc_o, 32'h0);
    chk({tag, ".stallreq_if"}, {31'b0, stallreq_if}, 32'h1);
    chk({tag, ".perf_stall_cnt"}, perf_stall_cnt, 32'h0);
    chk({tag, ".perf_discard_cnt"}, {16'b0, perf_discard_cnt}, 32'h0);
  endtask

  logic [15:0] exp_disc_one;

  initial begin
`ifdef IFETCH_PERF_EN
    exp_disc_one = 16'd1;
`else
    exp_disc_one = 16'd0;
`endif
    pc = '0; stall = 0; flush = 0;
    bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1 checkResetValues("reset");
    @(negedge clk);
    rst = 0;

    // Zero-wait memory: accept at 0x0, deliver next cycle, then fetch 0x4
    applyStimulus(32'h0, 0, 0, 1, 0, 32'h0);
    chk("first.req", {31'b0, s_req}, 32'h1);
    chk("first.addr", s_addr, 32'h0);
    applyStimulus(32'h4, 0, 0, 1, 1, 32'h1111_1111);
    chk("first.valid", {31'b0, s_valid}, 32'h1);
    chk("first.pc", s_pc, 32'h0);
    chk("first.stallreq", {31'b0, s_stallreq}, 32'h0);
    applyStimulus(32'h4, 0, 0, 1, 0, 32'h0);
    chk("second.addr", s_addr, 32'h4);
    applyStimulus(32'h100, 0, 0, 0, 1, 32'h2222_2222);
    chk("second.pc", s_pc, 32'h4);

    // Memory refuses the request for three cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h100, 0, 0, 0, 0, 32'h0);
      chk("busy.req", {31'b0, s_req}, 32'h1);
      chk("busy.addr", s_addr, 32'h100);
      chk("busy.stallreq", {31'b0, s_stallreq}, 32'h1);
      chk("busy.valid", {31'b0, s_valid}, 32'h0);
    end
    applyStimulus(32'h100, 0, 0, 1, 0, 32'h0);

    // Response under downstream stall is parked, delivered once stall drops
    applyStimulus(32'h104, 1, 0, 0, 1, 32'h2402_0005);
    chk("hold.valid0", {31'b0, s_valid}, 32'h0);
    applyStimulus(32'h104, 1, 0, 0, 0, 32'h0);
    chk("hold.valid1", {31'b0, s_valid}, 32'h0);
    applyStimulus(32'h104, 0, 0, 0, 0, 32'h0);
    chk("hold.inst", s_inst, 32'h2402_0005);
    chk("hold.pc", s_pc, 32'h100);
    applyStimulus(32'h104, 0, 0, 0, 0, 32'h0);
    chk("hold.once", {31'b0, s_valid}, 32'h0);

    // Flush while waiting: the returning data must vanish
    applyStimulus(32'h104, 0, 0, 1, 0, 32'h0);
    applyStimulus(32'hBFC0_0380, 0, 1, 0, 0, 32'h0);
    applyStimulus(32'hBFC0_0380, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("wflush.valid", {31'b0, s_valid}, 32'h0);
    applyStimulus(32'hBFC0_0380, 0, 0, 1, 0, 32'h0);
    chk("wflush.addr", s_addr, 32'hBFC0_0380);
    chk("wflush.discards", {16'b0, s_pdisc}, {16'b0, exp_disc_one});
    applyStimulus(32'hBFC0_0384, 0, 0, 0, 1, 32'h3333_3333);
    chk("wflush.pc", s_pc, 32'hBFC0_0380);

    // Flush in the same cycle the request is accepted
    applyStimulus(32'h200, 0, 1, 1, 0, 32'h0);
    applyStimulus(32'hBFC0_0380, 0, 0, 0, 1, 32'hBAD0_BAD0);
    chk("aflush.valid", {31'b0, s_valid}, 32'h0);
    applyStimulus(32'hBFC0_0380, 0, 0, 1, 0, 32'h0);
    applyStimulus(32'hBFC0_0384, 0, 0, 0, 1, 32'h4444_4444);
    chk("aflush.pc", s_pc, 32'hBFC0_0380);
    chk("aflush.valid1", {31'b0, s_valid}, 32'h1);

    // Reset asserted mid-transaction
    applyStimulus(32'h300, 0, 0, 1, 0, 32'h0);
    rst = 1; pc = 32'h400;
    bus.inst_addr_ok = 0; bus.inst_data_ok = 0;
    #1 checkResetValues("midrst");
    modelReset();
    repeat (2) @(negedge clk);
    rst = 0;
    applyStimulus(32'h400, 0, 0, 1, 0, 32'h0);
    chk("midrst.addr", s_addr, 32'h400);
    chk("midrst.req", {31'b0, s_req}, 32'h1);
    applyStimulus(32'h404, 0, 0, 0, 1, 32'h5555_5555);
    chk("midrst.pc", s_pc, 32'h400);

    repeat (3000) randomStep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
